// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA fetch > clear-screen engine > CPU, with a 2-stage read tag pipeline.
// The clear-screen engine is compiled in only when VRAM_CLEAR_EN is defined.
module vram_arbiter #(
    parameter int            AW       = 11,
    parameter int            DW       = 19,
    parameter int            DEPTH    = 2048,
    parameter logic [DW-1:0] CLR_WORD = 19'h60020
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_valid,
    output logic [DW-1:0] vga_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          vram_we,
    output logic [AW-1:0] vram_addr,
    output logic [DW-1:0] vram_din,
    input  logic [DW-1:0] vram_dout
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    tag_t          tag_issue;
    tag_t          tag_capture;
    logic          wr_ack_pend;
    logic          cpu_busy;
    logic          grant_vga;
    logic          grant_clr;
    logic          grant_cpu;
    logic [AW-1:0] clr_cnt;

`ifdef VRAM_CLEAR_EN
    // state    | meaning
    // CLR_IDLE | no clear in progress, clr_start accepted
    // CLR_RUN  | writing CLR_WORD at clr_cnt in every slot VGA leaves free
    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    clr_state_t clr_state;
    clr_state_t clr_state_nxt;
    logic       clr_last;

    assign clr_last  = (clr_cnt == AW'(DEPTH - 1));
    assign grant_clr = clr_busy && !vga_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state <= CLR_IDLE;
        end else begin
            clr_state <= clr_state_nxt;
        end
    end

    always_comb begin
        clr_state_nxt = clr_state;
        case (clr_state)
            CLR_IDLE: if (clr_start) clr_state_nxt = CLR_RUN;
            CLR_RUN:  if (grant_clr && clr_last) clr_state_nxt = CLR_IDLE;
            default:  clr_state_nxt = CLR_IDLE;
        endcase
    end

    always_comb begin
        clr_busy = (clr_state == CLR_RUN);
    end

    // Counter parks on the last address instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (clr_state == CLR_IDLE && clr_start) begin
            clr_cnt <= '0;
        end else if (grant_clr && !clr_last) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end
`else
    logic unused_clr;

    assign clr_busy   = 1'b0;
    assign grant_clr  = 1'b0;
    assign clr_cnt    = '0;
    assign unused_clr = clr_start ^ (^CLR_WORD) ^ DEPTH[0];
`endif

    assign grant_vga = vga_req;
    assign grant_cpu = cpu_req && !cpu_busy && !cpu_ack && !clr_busy && !vga_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_we     <= 1'b0;
            vram_addr   <= '0;
            vram_din    <= '0;
            tag_issue   <= TAG_NONE;
            tag_capture <= TAG_NONE;
            wr_ack_pend <= 1'b0;
            cpu_busy    <= 1'b0;
            vga_valid   <= 1'b0;
            vga_data    <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            vram_we     <= 1'b0;
            tag_issue   <= TAG_NONE;
            wr_ack_pend <= 1'b0;
            if (grant_vga) begin
                vram_addr <= vga_addr;
                tag_issue <= TAG_VGA;
            end else if (grant_clr) begin
                vram_we   <= 1'b1;
                vram_addr <= clr_cnt;
                vram_din  <= CLR_WORD;
            end else if (grant_cpu) begin
                vram_addr <= cpu_addr;
                if (cpu_we) begin
                    vram_we     <= 1'b1;
                    vram_din    <= cpu_wdata;
                    wr_ack_pend <= 1'b1;
                end else begin
                    tag_issue <= TAG_CPU;
                end
            end

            // VRAM registers its output, so the capture stage lines up with vram_dout
            tag_capture <= tag_issue;
            vga_valid   <= (tag_capture == TAG_VGA);
            if (tag_capture == TAG_VGA) begin
                vga_data <= vram_dout;
            end
            cpu_ack <= (tag_capture == TAG_CPU) || wr_ack_pend;
            if (tag_capture == TAG_CPU) begin
                cpu_rdata <= vram_dout;
            end

            if (grant_cpu) begin
                cpu_busy <= 1'b1;
            end else if (cpu_ack) begin
                cpu_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, corner sequences and a randomized
// run against a queue-based reference; clear-engine sections depend on VRAM_CLEAR_EN.
module tb_vram_arbiter;

    localparam int AW = 11;
    localparam int DW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_valid;
    logic [DW-1:0] vga_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          clr_start;
    logic          clr_busy;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_din;
    logic [DW-1:0] vram_dout;

    always #5 clk = ~clk;

    vram_arbiter #(
        .AW(AW), .DW(DW), .DEPTH(2048), .CLR_WORD(19'h60020)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_data(vga_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din), .vram_dout(vram_dout)
    );

    // VRAM stand-in with registered read data; preload fills addr + 0x100
    logic [DW-1:0] mem [0:2047];
    logic          preload_req = 1'b0;

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 19'(i + 'h100);
        end else if (vram_we) begin
            mem[vram_addr] <= vram_din;
        end
        vram_dout <= mem[vram_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
    endtask

    typedef struct {
        logic          is_vga;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] data;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    vec_t          tbl [11];
    resp_t         vq [$];
    logic [DW-1:0] model [0:2047];

    initial begin
        vec_t          v;
        int            lat, npulse, nother, cnt;
        logic          drop, exp_vv, exp_ack, cpu_pend, cpu_is_rd;
        logic [DW-1:0] cpu_exp, got;
        int            cpu_due, last_vga;
        int            remaining, busy_err, busy_cycles, wr_cnt, wr_err, exp_addr;
        int            nvga, vga_in, vga_out, fall_cyc, ack_cyc;
        logic          exp_busy;

        // {is_vga, we, addr, wdata, latency, expected read data / cpu_rdata after write}
        tbl[0]  = '{1'b0, 1'b1, 11'h005, 19'h12345, 2, 19'h00000};
        tbl[1]  = '{1'b0, 1'b0, 11'h005, 19'h00000, 3, 19'h12345};
        tbl[2]  = '{1'b1, 1'b0, 11'h005, 19'h00000, 3, 19'h12345};
        tbl[3]  = '{1'b1, 1'b0, 11'h7FF, 19'h00000, 3, 19'h008FF};
        tbl[4]  = '{1'b0, 1'b0, 11'h000, 19'h00000, 3, 19'h00100};
        tbl[5]  = '{1'b0, 1'b1, 11'h7FF, 19'h7FFFF, 2, 19'h00100};
        tbl[6]  = '{1'b1, 1'b0, 11'h7FF, 19'h00000, 3, 19'h7FFFF};
        tbl[7]  = '{1'b0, 1'b0, 11'h7FF, 19'h00000, 3, 19'h7FFFF};
        tbl[8]  = '{1'b1, 1'b0, 11'h000, 19'h00000, 3, 19'h00100};
        tbl[9]  = '{1'b0, 1'b1, 11'h000, 19'h00000, 2, 19'h7FFFF};
        tbl[10] = '{1'b0, 1'b0, 11'h000, 19'h00000, 3, 19'h00000};

        vga_req = 0; vga_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; clr_start = 0;
        for (int i = 0; i < 2048; i++) model[i] = 19'(i + 'h100);

        // Reset held for 3 cycles
        preload();
        tick();
        tick();
        check("rst_vga_valid", 32'(vga_valid), 0);
        check("rst_vga_data", 32'(vga_data), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_clr_busy", 32'(clr_busy), 0);
        check("rst_vram_we", 32'(vram_we), 0);
        check("rst_vram_addr", 32'(vram_addr), 0);
        check("rst_vram_din", 32'(vram_din), 0);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (vga_valid || cpu_ack || vram_we) cnt++;
        end
        check("post_reset_quiet", 32'(cnt), 0);

        // Directed single-transaction table
        for (int i = 0; i < 11; i++) begin
            v = tbl[i];
            if (v.is_vga) begin
                vga_req = 1; vga_addr = v.addr;
            end else begin
                cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
            end
            lat = -1; npulse = 0; nother = 0; drop = 0;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (k == 1) begin
                    vga_req = 0;
                    check($sformatf("vec%0d_vram_addr", i), 32'(vram_addr), 32'(v.addr));
                    check($sformatf("vec%0d_vram_we", i), 32'(vram_we), 32'(!v.is_vga && v.we));
                    if (!v.is_vga && v.we) check($sformatf("vec%0d_vram_din", i), 32'(vram_din), 32'(v.wdata));
                end
                if (drop) cpu_req = 0;
                if (v.is_vga ? vga_valid : cpu_ack) begin
                    npulse++;
                    if (lat < 0) lat = k;
                    if (v.is_vga) check($sformatf("vec%0d_vga_data", i), 32'(vga_data), 32'(v.data));
                    else if (!v.we) check($sformatf("vec%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(v.data));
                    if (!v.is_vga) drop = 1;
                end
                if (v.is_vga ? cpu_ack : vga_valid) nother++;
            end
            cpu_req = 0;
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.lat));
            check($sformatf("vec%0d_pulses", i), 32'(npulse), 1);
            check($sformatf("vec%0d_other_pulses", i), 32'(nother), 0);
            if (!v.is_vga && v.we) check($sformatf("vec%0d_rdata_kept", i), 32'(cpu_rdata), 32'(v.data));
        end

        // Same-cycle VGA and CPU read
        vga_req = 1; vga_addr = 11'h010; cpu_req = 1; cpu_we = 0; cpu_addr = 11'h020;
        tick();
        vga_req = 0;
        check("coll_addr_n1", 32'(vram_addr), 32'h010);
        tick();
        check("coll_addr_n2", 32'(vram_addr), 32'h020);
        check("coll_we_n2", 32'(vram_we), 0);
        tick();
        check("coll_vga_valid_n3", 32'(vga_valid), 1);
        check("coll_vga_data_n3", 32'(vga_data), 32'h110);
        check("coll_cpu_ack_n3", 32'(cpu_ack), 0);
        tick();
        check("coll_cpu_ack_n4", 32'(cpu_ack), 1);
        check("coll_cpu_rdata_n4", 32'(cpu_rdata), 32'h120);
        cpu_req = 0;
        tick();
        check("coll_cpu_ack_n5", 32'(cpu_ack), 0);

        // VGA burst every 2 cycles, addresses 0..7
        preload();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            vga_req = (k % 2 == 0) && (k < 16);
            vga_addr = 11'(k / 2);
            tick();
            exp_vv = (k >= 2) && ((k - 2) % 2 == 0) && (k - 2 < 16);
            check("burst_vga_valid", 32'(vga_valid), 32'(exp_vv));
            if (vga_valid) cnt++;
            if (exp_vv) check("burst_vga_data", 32'(vga_data), 32'(19'h100 + 19'((k - 2) / 2)));
        end
        vga_req = 0;
        check("burst_count", 32'(cnt), 8);

        // Randomized traffic: VGA on 0x000-0x0FF, CPU on 0x100-0x1FF, reference data from model
        preload();
        for (int i = 0; i < 2048; i++) model[i] = 19'(i + 'h100);
        cpu_pend = 0; cpu_due = -1; last_vga = -10; cpu_is_rd = 0; cpu_exp = 0;
        for (int t = 0; t < 1500; t++) begin
            exp_vv = (vq.size() > 0) && (vq[0].due == t);
            check("rnd_vga_valid", 32'(vga_valid), 32'(exp_vv));
            if (exp_vv) begin
                check("rnd_vga_data", 32'(vga_data), 32'(vq[0].data));
                void'(vq.pop_front());
            end
            exp_ack = cpu_pend && (cpu_due == t);
            check("rnd_cpu_ack", 32'(cpu_ack), 32'(exp_ack));
            if (exp_ack) begin
                if (cpu_is_rd) check("rnd_cpu_rdata", 32'(cpu_rdata), 32'(cpu_exp));
                cpu_pend = 0;
                cpu_req = 0;
            end
            vga_req = (t - last_vga >= 2) && ($urandom_range(2) == 0) && (t < 1490);
            if (vga_req) begin
                vga_addr = 11'($urandom_range(255));
                last_vga = t;
                vq.push_back('{t + 3, model[vga_addr]});
            end
            if (!cpu_pend && !exp_ack && t < 1480 && $urandom_range(1) == 1) begin
                cpu_req = 1;
                cpu_we = 1'($urandom_range(1));
                cpu_addr = 11'h100 + 11'($urandom_range(255));
                cpu_wdata = 19'($urandom);
                cpu_is_rd = !cpu_we;
                if (cpu_we) model[cpu_addr] = cpu_wdata;
                else cpu_exp = model[cpu_addr];
                cpu_due = (vga_req ? t + 1 : t) + (cpu_we ? 2 : 3);
                cpu_pend = 1;
            end
            tick();
        end
        vga_req = 0; cpu_req = 0;
        check("rnd_vga_drained", 32'(vq.size()), 0);

        // Reset aborts an in-flight VGA read and an in-flight CPU read
        for (int m = 0; m < 2; m++) begin
            if (m == 0) begin vga_req = 1; vga_addr = 11'h010; end
            else begin cpu_req = 1; cpu_we = 0; cpu_addr = 11'h020; end
            tick();
            vga_req = 0;
            tick();
            rst_n = 0;
            cpu_req = 0;
            #1;
            check("abort_vga_valid", 32'(vga_valid), 0);
            check("abort_cpu_ack", 32'(cpu_ack), 0);
            tick();
            tick();
            rst_n = 1;
            cnt = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (vga_valid || cpu_ack) cnt++;
            end
            check("abort_no_pulse", 32'(cnt), 0);
        end

`ifdef VRAM_CLEAR_EN
        // Full clear with VGA every 4 cycles and a CPU read issued mid-clear
        preload();
        clr_start = 1;
        tick();
        clr_start = 0;
        remaining = 2048; busy_err = 0; busy_cycles = 0; wr_cnt = 0; wr_err = 0; exp_addr = 0;
        nvga = 0; vga_in = 0; vga_out = 0; fall_cyc = -1; ack_cyc = -1; got = 0;
        for (int t = 0; t < 3000; t++) begin
            exp_busy = (remaining > 0);
            if (clr_busy !== exp_busy) busy_err++;
            if (clr_busy) busy_cycles++;
            if (!exp_busy && fall_cyc < 0) fall_cyc = t;
            if (vram_we) begin
                wr_cnt++;
                if (vram_addr !== 11'(exp_addr) || vram_din !== 19'h60020) wr_err++;
                exp_addr++;
            end
            if (vga_valid) vga_out++;
            if (cpu_ack && ack_cyc < 0) begin
                ack_cyc = t;
                got = cpu_rdata;
                cpu_req = 0;
            end
            vga_req = (t % 4 == 0) && (t < 1500);
            if (vga_req) begin
                vga_in++;
                vga_addr = 11'(t % 256);
            end
            if (t == 1000) begin cpu_req = 1; cpu_we = 0; cpu_addr = 11'h123; end
            if (exp_busy && vga_req) nvga++;
            if (exp_busy && !vga_req) remaining--;
            if (fall_cyc >= 0 && ack_cyc >= 0 && t > ack_cyc + 5) break;
            tick();
        end
        vga_req = 0; cpu_req = 0;
        check("clr_busy_track", 32'(busy_err), 0);
        check("clr_busy_cycles", 32'(busy_cycles), 32'(2048 + nvga));
        check("clr_write_count", 32'(wr_cnt), 2048);
        check("clr_write_bad", 32'(wr_err), 0);
        check("clr_vga_valids", 32'(vga_out), 32'(vga_in));
        check("clr_cpu_acked", 32'(ack_cyc >= 0), 1);
        check("clr_cpu_ack_delay", 32'(ack_cyc - fall_cyc), 3);
        check("clr_cpu_rdata", 32'(got), 32'h60020);

        // Reset while the clear counter sits at 0x100, then restart from 0
        clr_start = 1;
        tick();
        clr_start = 0;
        for (int k = 0; k < 256; k++) tick();
        check("clr_mid_last_addr", 32'(vram_addr), 32'h0FF);
        check("clr_mid_busy_pre", 32'(clr_busy), 1);
        rst_n = 0;
        #1;
        check("clr_mid_busy_rst", 32'(clr_busy), 0);
        check("clr_mid_we_rst", 32'(vram_we), 0);
        tick();
        tick();
        rst_n = 1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (vram_we || clr_busy) cnt++;
        end
        check("clr_mid_quiet", 32'(cnt), 0);
        clr_start = 1;
        tick();
        clr_start = 0;
        check("clr_restart_busy", 32'(clr_busy), 1);
        tick();
        check("clr_restart_we", 32'(vram_we), 1);
        check("clr_restart_addr", 32'(vram_addr), 0);
        rst_n = 0;
        tick();
        rst_n = 1;
`else
        // Without the clear engine clr_start has no effect
        clr_start = 1;
        tick();
        clr_start = 0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (clr_busy || vram_we) cnt++;
        end
        check("noclr_ignored", 32'(cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
